handshake_ctrl_a: RTL and testbench
===================================

HANDSHAKE_CTRL_A -- requirements
Module: handshake_ctrl_a

Interface
REQ-001 SHALL have ports: Clk  in  1  sole clock; all logic on its rising edge.
REQ-002 SHALL have ports: Reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: ModeEn  in  1  1 = Group A strobed mode (mode 1) active.
REQ-004 SHALL have ports: DirIn  in  1  1 = Port A input, 0 = Port A output; control word bit 4.
REQ-005 SHALL have ports: STB_n, ACK_n  in  1 each  peripheral strobe and acknowledge, active-low, Clk-synchronous.
REQ-006 SHALL have ports: RD_n, WR_n  in  1 each  CPU read/write of Port A, active-low, Clk-synchronous.
REQ-007 SHALL have ports: BsrValid  in  1; BsrBit  in  3; BsrVal  in  1  one-cycle bit set/reset command for port C.
REQ-008 SHALL have ports: PortIn  in  8  pins; CpuData  in  8  CPU write data.
REQ-009 SHALL have ports: LatchData  out  8  input latch; PortOut  out  8  output latch.
REQ-010 SHALL have ports: IBF  out  1; OBF_n  out  1; INTR  out  1; INTE  out  1; State  out  2  for debug.

Function
REQ-011 SHALL register STB_n, ACK_n, RD_n and WR_n each cycle; fall = prev 1 & cur 0; rise = prev 0 & cur 1.
REQ-012 SHALL apply all output updates at the same clock edge on which the edge is detected, with 1-cycle latency from the sampled pin change.
REQ-013 SHALL use FSM states IDLE, IN_FULL, OUT_PEND, OUT_ACK (2-bit encoding 0..3), exported on State.
REQ-014 Input path, STB fall in IDLE with ModeEn=1 and DirIn=1: SHALL load LatchData<=PortIn, set IBF=1 and go to IN_FULL.
REQ-015 Input path, STB rise in IN_FULL with INTE=1: SHALL set INTR=1.
REQ-016 Input path, RD fall: SHALL clear INTR.
REQ-017 Input path, RD rise in IN_FULL: SHALL clear IBF and return to IDLE.
REQ-018 SHALL ignore STB fall while in IN_FULL; LatchData is held and no overrun is flagged.
REQ-019 On the same cycle as RD rise (state IN_FULL), an STB fall SHALL be taken: LatchData<=PortIn, IBF stays 1, state stays IN_FULL.
REQ-020 Output path, WR fall with ModeEn=1 and DirIn=0: SHALL clear INTR.
REQ-021 Output path, WR rise: SHALL load PortOut<=CpuData, set OBF_n=0 and go to OUT_PEND; this applies from IDLE and, overwriting, from OUT_PEND.
REQ-022 Output path, ACK fall in OUT_PEND: SHALL set OBF_n=1 and go to OUT_ACK.
REQ-023 Output path, ACK rise in OUT_ACK: SHALL set INTR=INTE and return to IDLE.
REQ-024 A WR rise coincident with an ACK fall SHALL take priority: new data is loaded, OBF_n stays 0, state stays OUT_PEND.
REQ-025 INTE SHALL be set or cleared by BsrValid when BsrBit=4 and DirIn=1, or when BsrBit=6 and DirIn=0; other BsrBit values SHALL be ignored.
REQ-026 Clearing INTE SHALL clear INTR in the same cycle.
REQ-027 When ModeEn=0, or DirIn changes while ModeEn=1: state<=IDLE, IBF=0, OBF_n=1, INTR=0, INTE=0; latches are held.
REQ-028 Strobes of the inactive direction SHALL be ignored.

Reset
REQ-029 Reset=1 at a Clk edge SHALL force state IDLE, IBF=0, OBF_n=1, INTR=0, INTE=0, LatchData=8'h00 and PortOut=8'h00.
REQ-030 Reset SHALL load all edge-detector registers with 1, so no edge is detected on the first cycle after reset.
REQ-031 Reset SHALL dominate every other input, including mid-handshake.

Structure
REQ-032 Package ppi_pkg SHALL hold the FSM state type/encoding and the constants INTE_A_IN_BIT=4 and INTE_A_OUT_BIT=6.
REQ-033 Sub-module edge_det (registered sample, rise/fall outputs, reset-to-1) SHALL be instantiated four times.

Verification
REQ-034 Input cycle: INTE set via BSR bit4=1, PortIn=8'hA5, STB_n pulsed low 2 cycles -> LatchData=A5, IBF=1; INTR=1 one cycle after STB rise; RD_n pulse -> INTR=0 at RD fall, IBF=0 at RD rise.
REQ-035 Output cycle: DirIn=0, INTE set via BSR bit6, WR_n pulse with CpuData=8'h3C -> PortOut=3C, OBF_n=0; ACK_n fall -> OBF_n=1; ACK_n rise -> INTR=1.
REQ-036 STB fall while IBF=1 with PortIn=8'h11 -> LatchData keeps prior 8'hA5; STB fall coincident with RD rise with PortIn=8'h22 -> LatchData=22, IBF=1.
REQ-037 INTE=0 run of REQ-034 -> INTR never asserts; BSR bit4=0 while INTR=1 -> INTR=0 the next cycle.
REQ-038 Reset asserted in OUT_PEND (OBF_n=0) -> next cycle OBF_n=1, PortOut=00, State=IDLE, and no spurious edge on the following cycle.
REQ-039 DirIn toggled while in IN_FULL -> IBF=0, INTE=0, State=IDLE, LatchData unchanged.

Source files
------------

// File: rtl/ppi_pkg.sv
// Shared types and constants for the Group A strobed-mode handshake controller.
// State encoding is exported on the debug State port, so the values are fixed.
package ppi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IN_FULL  = 2'd1,
        ST_OUT_PEND = 2'd2,
        ST_OUT_ACK  = 2'd3
    } state_e;

    localparam logic [2:0] INTE_A_IN_BIT  = 3'd4;
    localparam logic [2:0] INTE_A_OUT_BIT = 3'd6;

    // The port C bit that owns INTE depends on which direction Port A is using.
    function automatic logic bsrHitsInte(input logic [2:0] bitSel, input logic dirIn);
        return (dirIn && bitSel == INTE_A_IN_BIT) || (!dirIn && bitSel == INTE_A_OUT_BIT);
    endfunction

endpackage

// File: rtl/edge_det.sv
// Registered edge detector for an active-low, clock-synchronous strobe.
// The sample register resets to 1 so an idle-high line never shows a false edge.
module edge_det (
    input  logic clk_i,
    input  logic reset_i,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= sig_i;
        end
    end

    assign fall_o = prev_q & ~sig_i;
    assign rise_o = ~prev_q & sig_i;

endmodule

// File: rtl/handshake_ctrl_a.sv
// Group A strobed-mode (mode 1) handshake controller for Port A.
// Edges are detected against the registered pin values and acted on at that same clock edge.
module handshake_ctrl_a
    import ppi_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ModeEn,
    input  logic       DirIn,
    input  logic       STB_n,
    input  logic       ACK_n,
    input  logic       RD_n,
    input  logic       WR_n,
    input  logic       BsrValid,
    input  logic [2:0] BsrBit,
    input  logic       BsrVal,
    input  logic [7:0] PortIn,
    input  logic [7:0] CpuData,
    output logic [7:0] LatchData,
    output logic [7:0] PortOut,
    output logic       IBF,
    output logic       OBF_n,
    output logic       INTR,
    output logic       INTE,
    output logic [1:0] State
);

    logic stbRise, stbFall, ackRise, ackFall;
    logic rdRise, rdFall, wrRise, wrFall;

    edge_det u_stb (.clk_i(Clk), .reset_i(Reset), .sig_i(STB_n), .rise_o(stbRise), .fall_o(stbFall));
    edge_det u_ack (.clk_i(Clk), .reset_i(Reset), .sig_i(ACK_n), .rise_o(ackRise), .fall_o(ackFall));
    edge_det u_rd  (.clk_i(Clk), .reset_i(Reset), .sig_i(RD_n),  .rise_o(rdRise),  .fall_o(rdFall));
    edge_det u_wr  (.clk_i(Clk), .reset_i(Reset), .sig_i(WR_n),  .rise_o(wrRise),  .fall_o(wrFall));

    state_e     state_q, state_d;
    logic [7:0] latch_q, latch_d;
    logic [7:0] portOut_q, portOut_d;
    logic       ibf_q, ibf_d;
    logic       obfN_q, obfN_d;
    logic       intr_q, intr_d;
    logic       inte_q, inte_d;
    logic       dirPrev_q;
    logic       dirChange;

    assign dirChange = ModeEn && (dirPrev_q != DirIn);

    always_ff @(posedge Clk) begin
        dirPrev_q <= DirIn;
        if (Reset) begin
            state_q   <= ST_IDLE;
            latch_q   <= 8'h00;
            portOut_q <= 8'h00;
            ibf_q     <= 1'b0;
            obfN_q    <= 1'b1;
            intr_q    <= 1'b0;
            inte_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            latch_q   <= latch_d;
            portOut_q <= portOut_d;
            ibf_q     <= ibf_d;
            obfN_q    <= obfN_d;
            intr_q    <= intr_d;
            inte_q    <= inte_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        latch_d   = latch_q;
        portOut_d = portOut_q;
        ibf_d     = ibf_q;
        obfN_d    = obfN_q;
        intr_d    = intr_q;
        inte_d    = inte_q;

        // Leaving the mode or flipping direction abandons any handshake but keeps the data latches.
        if (!ModeEn || dirChange) begin
            state_d = ST_IDLE;
            ibf_d   = 1'b0;
            obfN_d  = 1'b1;
            intr_d  = 1'b0;
            inte_d  = 1'b0;
        end else begin
            if (BsrValid && bsrHitsInte(BsrBit, DirIn)) begin
                inte_d = BsrVal;
            end

            if (DirIn) begin
                case (state_q)
                    ST_IDLE: begin
                        if (stbFall) begin
                            latch_d = PortIn;
                            ibf_d   = 1'b1;
                            state_d = ST_IN_FULL;
                        end
                    end
                    ST_IN_FULL: begin
                        if (stbRise && inte_q) begin
                            intr_d = 1'b1;
                        end
                        // A strobe landing on the read-completion edge refills the latch at once.
                        if (rdRise) begin
                            if (stbFall) begin
                                latch_d = PortIn;
                            end else begin
                                ibf_d   = 1'b0;
                                state_d = ST_IDLE;
                            end
                        end
                    end
                    default: ;
                endcase
                if (rdFall) begin
                    intr_d = 1'b0;
                end
            end else begin
                if (wrFall) begin
                    intr_d = 1'b0;
                end
                case (state_q)
                    ST_IDLE: begin
                        if (wrRise) begin
                            portOut_d = CpuData;
                            obfN_d    = 1'b0;
                            state_d   = ST_OUT_PEND;
                        end
                    end
                    ST_OUT_PEND: begin
                        if (wrRise) begin
                            portOut_d = CpuData;
                            obfN_d    = 1'b0;
                        end else if (ackFall) begin
                            obfN_d  = 1'b1;
                            state_d = ST_OUT_ACK;
                        end
                    end
                    ST_OUT_ACK: begin
                        if (ackRise) begin
                            intr_d  = inte_q;
                            state_d = ST_IDLE;
                        end
                    end
                    default: ;
                endcase
            end

            if (!inte_d) begin
                intr_d = 1'b0;
            end
        end
    end

    assign LatchData = latch_q;
    assign PortOut   = portOut_q;
    assign IBF       = ibf_q;
    assign OBF_n     = obfN_q;
    assign INTR      = intr_q;
    assign INTE      = inte_q;
    assign State     = state_q;

endmodule

// File: tb/tb_handshake_ctrl_a.sv
// Directed self-checking bench for the Group A handshake controller.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_handshake_ctrl_a;

    logic       Clk = 1'b0;
    logic       Reset, ModeEn, DirIn;
    logic       STB_n, ACK_n, RD_n, WR_n;
    logic       BsrValid, BsrVal;
    logic [2:0] BsrBit;
    logic [7:0] PortIn, CpuData;
    logic [7:0] LatchData, PortOut;
    logic       IBF, OBF_n, INTR, INTE;
    logic [1:0] State;

    int checks   = 0;
    int failures = 0;

    handshake_ctrl_a dut (
        .Clk(Clk), .Reset(Reset), .ModeEn(ModeEn), .DirIn(DirIn),
        .STB_n(STB_n), .ACK_n(ACK_n), .RD_n(RD_n), .WR_n(WR_n),
        .BsrValid(BsrValid), .BsrBit(BsrBit), .BsrVal(BsrVal),
        .PortIn(PortIn), .CpuData(CpuData),
        .LatchData(LatchData), .PortOut(PortOut),
        .IBF(IBF), .OBF_n(OBF_n), .INTR(INTR), .INTE(INTE), .State(State)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic doReset();
        Reset = 1'b1; STB_n = 1'b1; ACK_n = 1'b1; RD_n = 1'b1; WR_n = 1'b1; BsrValid = 1'b0;
        tick();
        Reset = 1'b0;
    endtask

    task automatic bsr(input logic [2:0] b, input logic v);
        BsrValid = 1'b1; BsrBit = b; BsrVal = v;
        tick();
        BsrValid = 1'b0;
    endtask

    task automatic test_reset();
        ModeEn = 1'b1; DirIn = 1'b1; PortIn = 8'hFF; CpuData = 8'hFF;
        doReset();
        checks++; if (State !== 2'd0)      begin failures++; $display("FAIL rst_state got=%0h exp=0", State); end
        checks++; if (IBF !== 1'b0)        begin failures++; $display("FAIL rst_ibf got=%0b exp=0", IBF); end
        checks++; if (OBF_n !== 1'b1)      begin failures++; $display("FAIL rst_obf got=%0b exp=1", OBF_n); end
        checks++; if (INTR !== 1'b0)       begin failures++; $display("FAIL rst_intr got=%0b exp=0", INTR); end
        checks++; if (INTE !== 1'b0)       begin failures++; $display("FAIL rst_inte got=%0b exp=0", INTE); end
        checks++; if (LatchData !== 8'h00) begin failures++; $display("FAIL rst_latch got=%0h exp=00", LatchData); end
        checks++; if (PortOut !== 8'h00)   begin failures++; $display("FAIL rst_portout got=%0h exp=00", PortOut); end
    endtask

    task automatic test_input_cycle();
        bsr(3'd4, 1'b1);
        checks++; if (INTE !== 1'b1) begin failures++; $display("FAIL in_inte got=%0b exp=1", INTE); end
        PortIn = 8'hA5; STB_n = 1'b0;
        tick();
        checks++; if (LatchData !== 8'hA5) begin failures++; $display("FAIL in_latch got=%0h exp=a5", LatchData); end
        checks++; if (IBF !== 1'b1)        begin failures++; $display("FAIL in_ibf got=%0b exp=1", IBF); end
        checks++; if (State !== 2'd1)      begin failures++; $display("FAIL in_state got=%0h exp=1", State); end
        tick();
        checks++; if (INTR !== 1'b0) begin failures++; $display("FAIL in_intr_early got=%0b exp=0", INTR); end
        STB_n = 1'b1;
        tick();
        checks++; if (INTR !== 1'b1) begin failures++; $display("FAIL in_intr_set got=%0b exp=1", INTR); end
        RD_n = 1'b0;
        tick();
        checks++; if (INTR !== 1'b0) begin failures++; $display("FAIL in_intr_rdfall got=%0b exp=0", INTR); end
        checks++; if (IBF !== 1'b1)  begin failures++; $display("FAIL in_ibf_rdfall got=%0b exp=1", IBF); end
        RD_n = 1'b1;
        tick();
        checks++; if (IBF !== 1'b0)   begin failures++; $display("FAIL in_ibf_rdrise got=%0b exp=0", IBF); end
        checks++; if (State !== 2'd0) begin failures++; $display("FAIL in_state_idle got=%0h exp=0", State); end
    endtask

    task automatic test_overrun();
        PortIn = 8'hA5; STB_n = 1'b0; tick();
        STB_n = 1'b1; tick();
        PortIn = 8'h11; STB_n = 1'b0;
        tick();
        checks++; if (LatchData !== 8'hA5) begin failures++; $display("FAIL ovr_hold got=%0h exp=a5", LatchData); end
        checks++; if (State !== 2'd1)      begin failures++; $display("FAIL ovr_state got=%0h exp=1", State); end
        STB_n = 1'b1; tick();
        RD_n = 1'b0; tick();
        RD_n = 1'b1; STB_n = 1'b0; PortIn = 8'h22;
        tick();
        checks++; if (LatchData !== 8'h22) begin failures++; $display("FAIL ovr_refill got=%0h exp=22", LatchData); end
        checks++; if (IBF !== 1'b1)        begin failures++; $display("FAIL ovr_ibf got=%0b exp=1", IBF); end
        checks++; if (State !== 2'd1)      begin failures++; $display("FAIL ovr_refill_state got=%0h exp=1", State); end
        STB_n = 1'b1; tick();
        RD_n = 1'b0; tick();
        RD_n = 1'b1; tick();
        checks++; if (State !== 2'd0) begin failures++; $display("FAIL ovr_drain got=%0h exp=0", State); end
    endtask

    task automatic test_inte_off();
        DirIn = 1'b1;
        doReset();
        bsr(3'd6, 1'b1);
        checks++; if (INTE !== 1'b0) begin failures++; $display("FAIL ioff_wrongbit got=%0b exp=0", INTE); end
        PortIn = 8'h5A; STB_n = 1'b0; tick(); tick();
        STB_n = 1'b1; tick();
        checks++; if (INTR !== 1'b0)       begin failures++; $display("FAIL ioff_intr got=%0b exp=0", INTR); end
        checks++; if (LatchData !== 8'h5A) begin failures++; $display("FAIL ioff_latch got=%0h exp=5a", LatchData); end
        RD_n = 1'b0; tick();
        RD_n = 1'b1; tick();
        checks++; if (IBF !== 1'b0) begin failures++; $display("FAIL ioff_ibf got=%0b exp=0", IBF); end
        CpuData = 8'h99; WR_n = 1'b0; tick();
        WR_n = 1'b1; tick();
        checks++; if (PortOut !== 8'h00) begin failures++; $display("FAIL ioff_wr_ignored got=%0h exp=00", PortOut); end
        checks++; if (State !== 2'd0)    begin failures++; $display("FAIL ioff_wr_state got=%0h exp=0", State); end
        bsr(3'd4, 1'b1);
        STB_n = 1'b0; tick();
        STB_n = 1'b1; tick();
        checks++; if (INTR !== 1'b1) begin failures++; $display("FAIL ioff_intr_on got=%0b exp=1", INTR); end
        bsr(3'd4, 1'b0);
        checks++; if (INTR !== 1'b0) begin failures++; $display("FAIL ioff_clr_intr got=%0b exp=0", INTR); end
        checks++; if (INTE !== 1'b0) begin failures++; $display("FAIL ioff_clr_inte got=%0b exp=0", INTE); end
        RD_n = 1'b0; tick();
        RD_n = 1'b1; tick();
    endtask

    task automatic test_output_cycle();
        DirIn = 1'b0;
        doReset();
        bsr(3'd6, 1'b1);
        checks++; if (INTE !== 1'b1) begin failures++; $display("FAIL out_inte got=%0b exp=1", INTE); end
        CpuData = 8'h3C; WR_n = 1'b0; tick();
        WR_n = 1'b1; tick();
        checks++; if (PortOut !== 8'h3C) begin failures++; $display("FAIL out_data got=%0h exp=3c", PortOut); end
        checks++; if (OBF_n !== 1'b0)    begin failures++; $display("FAIL out_obf got=%0b exp=0", OBF_n); end
        checks++; if (State !== 2'd2)    begin failures++; $display("FAIL out_state got=%0h exp=2", State); end
        ACK_n = 1'b0; tick();
        checks++; if (OBF_n !== 1'b1) begin failures++; $display("FAIL out_ack_obf got=%0b exp=1", OBF_n); end
        checks++; if (State !== 2'd3) begin failures++; $display("FAIL out_ack_state got=%0h exp=3", State); end
        checks++; if (INTR !== 1'b0)  begin failures++; $display("FAIL out_ack_intr got=%0b exp=0", INTR); end
        ACK_n = 1'b1; tick();
        checks++; if (INTR !== 1'b1)  begin failures++; $display("FAIL out_intr got=%0b exp=1", INTR); end
        checks++; if (State !== 2'd0) begin failures++; $display("FAIL out_idle got=%0h exp=0", State); end
    endtask

    task automatic test_wr_ack_priority();
        CpuData = 8'h55; WR_n = 1'b0; tick();
        checks++; if (INTR !== 1'b0) begin failures++; $display("FAIL pri_wrfall_intr got=%0b exp=0", INTR); end
        WR_n = 1'b1; tick();
        checks++; if (PortOut !== 8'h55) begin failures++; $display("FAIL pri_first got=%0h exp=55", PortOut); end
        WR_n = 1'b0; tick();
        CpuData = 8'h66; WR_n = 1'b1; ACK_n = 1'b0;
        tick();
        checks++; if (PortOut !== 8'h66) begin failures++; $display("FAIL pri_data got=%0h exp=66", PortOut); end
        checks++; if (OBF_n !== 1'b0)    begin failures++; $display("FAIL pri_obf got=%0b exp=0", OBF_n); end
        checks++; if (State !== 2'd2)    begin failures++; $display("FAIL pri_state got=%0h exp=2", State); end
        ACK_n = 1'b1; tick();
    endtask

    task automatic test_reset_mid();
        Reset = 1'b1; WR_n = 1'b0; CpuData = 8'h77;
        tick();
        checks++; if (OBF_n !== 1'b1)    begin failures++; $display("FAIL rmid_obf got=%0b exp=1", OBF_n); end
        checks++; if (PortOut !== 8'h00) begin failures++; $display("FAIL rmid_portout got=%0h exp=00", PortOut); end
        checks++; if (State !== 2'd0)    begin failures++; $display("FAIL rmid_state got=%0h exp=0", State); end
        checks++; if (INTE !== 1'b0)     begin failures++; $display("FAIL rmid_inte got=%0b exp=0", INTE); end
        Reset = 1'b0; WR_n = 1'b1;
        tick();
        checks++; if (State !== 2'd0)    begin failures++; $display("FAIL rmid_noedge_state got=%0h exp=0", State); end
        checks++; if (PortOut !== 8'h00) begin failures++; $display("FAIL rmid_noedge_data got=%0h exp=00", PortOut); end
        checks++; if (OBF_n !== 1'b1)    begin failures++; $display("FAIL rmid_noedge_obf got=%0b exp=1", OBF_n); end
    endtask

    task automatic test_dir_change();
        DirIn = 1'b1; ModeEn = 1'b1;
        doReset();
        bsr(3'd4, 1'b1);
        PortIn = 8'hC3; STB_n = 1'b0; tick();
        STB_n = 1'b1; tick();
        checks++; if (IBF !== 1'b1)  begin failures++; $display("FAIL dir_pre_ibf got=%0b exp=1", IBF); end
        checks++; if (INTR !== 1'b1) begin failures++; $display("FAIL dir_pre_intr got=%0b exp=1", INTR); end
        DirIn = 1'b0; tick();
        checks++; if (IBF !== 1'b0)        begin failures++; $display("FAIL dir_ibf got=%0b exp=0", IBF); end
        checks++; if (INTE !== 1'b0)       begin failures++; $display("FAIL dir_inte got=%0b exp=0", INTE); end
        checks++; if (INTR !== 1'b0)       begin failures++; $display("FAIL dir_intr got=%0b exp=0", INTR); end
        checks++; if (State !== 2'd0)      begin failures++; $display("FAIL dir_state got=%0h exp=0", State); end
        checks++; if (LatchData !== 8'hC3) begin failures++; $display("FAIL dir_latch got=%0h exp=c3", LatchData); end
        ModeEn = 1'b0; tick();
        CpuData = 8'hAA; WR_n = 1'b0; tick();
        WR_n = 1'b1; tick();
        checks++; if (PortOut !== 8'h00) begin failures++; $display("FAIL mode_off_data got=%0h exp=00", PortOut); end
        checks++; if (State !== 2'd0)    begin failures++; $display("FAIL mode_off_state got=%0h exp=0", State); end
        checks++; if (OBF_n !== 1'b1)    begin failures++; $display("FAIL mode_off_obf got=%0b exp=1", OBF_n); end
        ModeEn = 1'b1; tick();
    endtask

    initial begin
        Reset = 1'b1; ModeEn = 1'b1; DirIn = 1'b1;
        STB_n = 1'b1; ACK_n = 1'b1; RD_n = 1'b1; WR_n = 1'b1;
        BsrValid = 1'b0; BsrBit = 3'd0; BsrVal = 1'b0;
        PortIn = 8'h00; CpuData = 8'h00;
        test_reset();
        test_input_cycle();
        test_overrun();
        test_inte_off();
        test_output_cycle();
        test_wr_ack_priority();
        test_reset_mid();
        test_dir_change();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
